// File: rtl/harq_send_ctrl.sv
// harq_send_ctrl: drains one finished combine buffer (ping or pong) to HARQ
// storage. Each 10-bit signed lane is saturated to 8 bits and streamed out
// through a 2-entry FIFO over valid/ready. A one-cycle Comp pulse marks the
// end of a drain. Clipped lanes are counted in o_Sat_Count.
module harq_send_ctrl #(
  parameter int LANES      = 16,
  parameter int IN_W       = 10,
  parameter int OUT_W      = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rstn,
  input  logic                    i_SENDHARQ_Data_request,
  input  logic                    i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]             i_SENDHARQ_Data_ncb,
  output logic [ADDR_WIDTH-1:0]   o_SENDHARQ_Data_Address,
  input  logic [LANES*IN_W-1:0]   i_Ping_Read_Data,
  input  logic [LANES*IN_W-1:0]   i_Pong_Read_Data,
  output logic                    o_SENDHARQ_Data_Comp,
  output logic                    o_HARQ_Valid,
  input  logic                    i_HARQ_Ready,
  output logic [LANES*OUT_W-1:0]  o_HARQ_Data,
  output logic                    o_HARQ_Last,
  output logic [15:0]             o_Sat_Count
);

  localparam int DW = LANES * OUT_W;
  localparam int CW = $clog2(LANES + 1);
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic                    ind_q, ind_d;
  logic                    infl_q, infl_last_q;
  logic [1:0]              cnt_q, cnt_d;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]           fifo_data_q [2];
  logic [1:0]              fifo_last_q;
  logic [15:0]             sat_q, sat_d;
  logic                    issue, push, pop, clr_sat, at_last;
  logic [LANES*IN_W-1:0]   src_word;
  logic signed [IN_W-1:0]  lane_v;
  logic [DW-1:0]           sat_word;
  logic [CW-1:0]           clip_cnt;
  logic [16:0]             sat_sum;
  logic                    unused_ncb;

  // Only ncb[14:4] sets the word range; the rest of ncb is deliberately ignored.
  assign unused_ncb = ^{i_SENDHARQ_Data_ncb[15:ADDR_WIDTH+4], i_SENDHARQ_Data_ncb[3:0]};

  // The RAM word returned this cycle enters the FIFO at the next edge. Reads
  // are credited against the post-pop occupancy so a steady stream runs at one
  // word per cycle without ever overfilling the two entries.
  assign push    = infl_q;
  assign pop     = o_HARQ_Valid & i_HARQ_Ready;
  assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
  assign at_last = (addr_q == last_addr_q);

  assign o_HARQ_Valid            = (cnt_q != 2'd0);
  assign o_HARQ_Data             = o_HARQ_Valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_HARQ_Last             = o_HARQ_Valid & fifo_last_q[rd_ptr_q];
  assign o_SENDHARQ_Data_Comp    = (state_q == ST_DONE);
  assign o_SENDHARQ_Data_Address = addr_q;
  assign o_Sat_Count             = sat_q;

  // Next-state logic: start on request, issue credited reads, wait for empty, pulse Comp.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    ind_d       = ind_q;
    issue       = 1'b0;
    clr_sat     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (i_SENDHARQ_Data_request) begin
          state_d     = ST_READ;
          ind_d       = i_SENDHARQ_Data_PingPong_Indicator;
          last_addr_d = i_SENDHARQ_Data_ncb[ADDR_WIDTH+3:4];
          clr_sat     = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_d < 2'd2) begin
          issue = 1'b1;
          if (at_last) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!infl_q && (cnt_d == 2'd0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturate every lane of the selected buffer word and count the clipped lanes.
  always_comb begin
    sat_word = '0;
    clip_cnt = '0;
    lane_v   = '0;
    src_word = ind_q ? i_Ping_Read_Data : i_Pong_Read_Data;
    for (int i = 0; i < LANES; i++) begin
      lane_v = src_word[i*IN_W +: IN_W];
      if (lane_v > SAT_MAX) begin
        sat_word[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        clip_cnt = clip_cnt + CW'(1);
      end else if (lane_v < SAT_MIN) begin
        sat_word[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        clip_cnt = clip_cnt + CW'(1);
      end else begin
        sat_word[i*OUT_W +: OUT_W] = lane_v[OUT_W-1:0];
      end
    end
  end

  // Clip counter clears at drain start and sticks at all-ones instead of wrapping.
  always_comb begin
    sat_d   = sat_q;
    sat_sum = {1'b0, sat_q} + 17'(clip_cnt);
    if (clr_sat) begin
      sat_d = '0;
    end else if (push) begin
      sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  // FSM state register.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain control registers: address, latched request fields, in-flight read tag, clip count.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      addr_q      <= '0;
      last_addr_q <= '0;
      ind_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      sat_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      ind_q       <= ind_d;
      infl_q      <= issue;
      infl_last_q <= issue & at_last;
      sat_q       <= sat_d;
    end
  end

  // Two-entry output FIFO holding saturated words and their Last flags.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_last_q <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sat_word;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_harq_send_ctrl.sv
// tb_harq_send_ctrl: drives drains of randomly filled ping/pong buffers and
// compares every delivered word, Last flag, Comp timing and clip count with a
// lane-by-lane model of the saturation rules.
module tb_harq_send_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         ind;
  logic [15:0]  ncb;
  logic [10:0]  addr;
  logic [159:0] pingQ;
  logic [159:0] pongQ;
  logic         comp;
  logic         valid;
  logic         ready;
  logic [127:0] data;
  logic         last;
  logic [15:0]  satCount;

  logic [159:0] pingMem [2048];
  logic [159:0] pongMem [2048];
  logic [127:0] expQ [$];
  int           expSat;
  int           assertCount = 0;
  int           failCount   = 0;

  // 100 MHz-style core clock.
  always #5 clk = ~clk;

  // Registered-read buffer RAMs sharing the DUT address port.
  always @(posedge clk) begin
    pingQ <= pingMem[addr];
    pongQ <= pongMem[addr];
  end

  harq_send_ctrl dut (
    .i_core_clk                         (clk),
    .i_rx_rstn                          (rst_n),
    .i_SENDHARQ_Data_request            (req),
    .i_SENDHARQ_Data_PingPong_Indicator (ind),
    .i_SENDHARQ_Data_ncb                (ncb),
    .o_SENDHARQ_Data_Address            (addr),
    .i_Ping_Read_Data                   (pingQ),
    .i_Pong_Read_Data                   (pongQ),
    .o_SENDHARQ_Data_Comp               (comp),
    .o_HARQ_Valid                       (valid),
    .i_HARQ_Ready                       (ready),
    .o_HARQ_Data                        (data),
    .o_HARQ_Last                        (last),
    .o_Sat_Count                        (satCount)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Fill the first n words of both buffers; pattern 1 = ping lanes all 5, pattern 2 = pong saturation corners.
  task automatic fillMems(input int n, input int pattern);
    for (int a = 0; a < n; a++) begin
      for (int l = 0; l < 16; l++) begin
        pingMem[a][l*10 +: 10] = 10'($urandom);
        pongMem[a][l*10 +: 10] = 10'($urandom);
        if (pattern == 1) pingMem[a][l*10 +: 10] = 10'(5);
      end
    end
    if (pattern == 2) begin
      pongMem[0]        = '0;
      pongMem[0][9:0]   = 10'(300);
      pongMem[0][19:10] = 10'(-300);
      pongMem[0][29:20] = 10'(127);
      pongMem[0][39:30] = 10'(-128);
    end
  endtask

  // Reference: expected output words and clip total, from integer lane values.
  task automatic buildModel(input logic selPing, input int n);
    logic [159:0] src;
    logic [127:0] word;
    int           v;
    int           o;
    expQ.delete();
    expSat = 0;
    for (int a = 0; a < n; a++) begin
      src  = selPing ? pingMem[a] : pongMem[a];
      word = '0;
      for (int l = 0; l < 16; l++) begin
        v = int'($signed(src[l*10 +: 10]));
        if (v > 127) begin
          o = 127;
          expSat++;
        end else if (v < -128) begin
          o = -128;
          expSat++;
        end else begin
          o = v;
        end
        word[l*8 +: 8] = o[7:0];
      end
      expQ.push_back(word);
    end
    if (expSat > 65535) expSat = 65535;
  endtask

  // One cycle expected to be idle: no Comp, no valid, address parked at 0.
  task automatic idleCycle();
    @(negedge clk);
    checkOutput("idle_comp", 128'(comp), 128'(0));
    checkOutput("idle_valid", 128'(valid), 128'(0));
    checkOutput("idle_addr", 128'(addr), 128'(0));
  endtask

  // Run one drain from an IDLE negedge. readyMode 0 = always ready, 1 = random.
  // flipAfter toggles the live indicator after that many words; resetAtWord
  // pulls reset while that word is presented; keepReq leaves the request high.
  task automatic applyStimulus(input logic selPing, input logic [15:0] ncbArg, input int pattern,
                               input int readyMode, input int flipAfter, input int resetAtWord,
                               input bit keepReq);
    int           n;
    int           hs;
    int           lastHs;
    int           cyc;
    int           prevAddr;
    int           curAddr;
    int           expAddr;
    bit           done;
    bit           prevStall;
    logic [127:0] prevData;
    logic         prevLast;
    n = int'(ncbArg[15:4]) + 1;
    fillMems(n, pattern);
    buildModel(selPing, n);
    ind       = selPing;
    ncb       = ncbArg;
    req       = 1'b1;
    ready     = 1'b0;
    hs        = 0;
    lastHs    = -10;
    cyc       = 0;
    prevAddr  = 0;
    done      = 1'b0;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!keepReq) req = 1'b0;
      if (cyc == 1) begin
        checkOutput("start_addr", 128'(addr), 128'(0));
        checkOutput("start_sat_cleared", 128'(satCount), 128'(0));
        checkOutput("start_valid", 128'(valid), 128'(0));
      end
      if (resetAtWord >= 0 && valid && hs == resetAtWord) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_addr", 128'(addr), 128'(0));
        checkOutput("rst_comp", 128'(comp), 128'(0));
        checkOutput("rst_valid", 128'(valid), 128'(0));
        checkOutput("rst_data", data, 128'(0));
        checkOutput("rst_last", 128'(last), 128'(0));
        checkOutput("rst_sat", 128'(satCount), 128'(0));
        repeat (3) begin
          @(negedge clk);
          checkOutput("rst_hold_comp", 128'(comp), 128'(0));
          checkOutput("rst_hold_valid", 128'(valid), 128'(0));
        end
        rst_n = 1'b1;
        done  = 1'b1;
      end else begin
        curAddr = int'(addr);
        if (prevStall) begin
          checkOutput("stall_valid", 128'(valid), 128'(1));
          checkOutput("stall_data", data, prevData);
          checkOutput("stall_last", 128'(last), 128'(prevLast));
        end
        checkOutput("addr_step", 128'((curAddr == prevAddr) || (curAddr == prevAddr + 1)), 128'(1));
        checkOutput("outstanding", 128'(curAddr - hs <= 2), 128'(1));
        prevAddr = curAddr;
        if (comp) begin
          checkOutput("comp_after_last", 128'(lastHs), 128'(cyc - 1));
          checkOutput("word_total", 128'(hs), 128'(n));
          checkOutput("sat_count", 128'(satCount), 128'(expSat));
          if (readyMode == 0) checkOutput("comp_latency", 128'(cyc), 128'(n + 3));
          done = 1'b1;
        end else begin
          if (readyMode == 0) begin
            expAddr = (cyc - 1 < n - 1) ? cyc - 1 : n - 1;
            checkOutput("stream_addr", 128'(curAddr), 128'(expAddr));
            checkOutput("valid_timing", 128'(valid), 128'(cyc >= 3 && cyc <= n + 2));
            ready = 1'b1;
          end else begin
            ready = 1'($urandom_range(0, 1));
          end
          if (valid && ready) begin
            if (hs < n) begin
              checkOutput($sformatf("word%0d_data", hs), data, expQ[hs]);
              checkOutput($sformatf("word%0d_last", hs), 128'(last), 128'(hs == n - 1));
            end else begin
              checkOutput("extra_word", 128'(hs + 1), 128'(n));
            end
            hs++;
            lastHs = cyc;
            if (hs == flipAfter) ind = ~ind;
          end
          prevStall = valid && !ready;
          prevData  = data;
          prevLast  = last;
        end
      end
    end
    checkOutput("drain_finished", 128'(done), 128'(1));
  endtask

  // Test sequence: reset values, directed scenarios, then random drains.
  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    ind   = 1'b0;
    ncb   = '0;
    ready = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      pingMem[a] = '0;
      pongMem[a] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_addr", 128'(addr), 128'(0));
    checkOutput("reset_comp", 128'(comp), 128'(0));
    checkOutput("reset_valid", 128'(valid), 128'(0));
    checkOutput("reset_data", data, 128'(0));
    checkOutput("reset_last", 128'(last), 128'(0));
    checkOutput("reset_sat", 128'(satCount), 128'(0));
    rst_n = 1'b1;
    idleCycle();

    $display("[TB] basic ping drain");
    applyStimulus(1'b1, 16'd64, 1, 0, -1, -1, 1'b0);
    idleCycle();

    $display("[TB] saturation corners");
    applyStimulus(1'b0, 16'd0, 2, 0, -1, -1, 1'b0);
    checkOutput("sat_word_exact", 128'(expQ[0][31:0]), 128'(32'h807F807F));
    idleCycle();

    $display("[TB] backpressure");
    applyStimulus(1'b0, 16'd160, 0, 1, -1, -1, 1'b0);
    idleCycle();

    $display("[TB] indicator flip mid-drain");
    applyStimulus(1'b1, 16'd144, 0, 1, 3, -1, 1'b0);
    idleCycle();

    $display("[TB] back-to-back requests");
    applyStimulus(1'b0, 16'd48, 0, 0, -1, -1, 1'b1);
    idleCycle();
    applyStimulus(1'b1, 16'd37, 0, 0, -1, -1, 1'b0);
    idleCycle();

    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 16'd112, 0, 0, -1, 2, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 16'd80, 0, 0, -1, -1, 1'b0);
    idleCycle();

    $display("[TB] random drains");
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 319)), 0,
                    int'($urandom_range(0, 1)), -1, -1, 1'b0);
      idleCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
